display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter PRESCALE, default 1000, SHALL set the clocks per digit slot; legal range 2..65535.
REQ-002 Parameter NUM_DIGITS, default 8, SHALL set the digits scanned per frame; legal range 2..8.
REQ-003 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run  input  1  scan enable; high = scanning, low = idle.
REQ-006 digits_in  input  32  eight BCD nibbles; digit k at bits [4k+3:4k].
REQ-007 load  input  1  single-cycle request to capture digits_in.
REQ-008 sel  output  3  digit index; drives the 3-to-8 decoder select S.
REQ-009 dec_en  output  1  drives the decoder enable; high = digit lit.
REQ-010 digit_out  output  4  BCD value of digit sel from the display register.
REQ-011 frame_done  output  1  one-cycle pulse on frame wrap.
REQ-012 load_ack  output  1  one-cycle pulse when staged data reaches the display register.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 FSM states: IDLE, ACTIVE, GAP.
REQ-015 IDLE: dec_en=0, sel=0, prescaler=0; go to ACTIVE when run=1.
REQ-016 ACTIVE: dec_en=1 for PRESCALE-1 cycles, then GAP; this gives anti-ghost blanking.
REQ-017 GAP: dec_en=0 for exactly 1 cycle; sel advances by 1 on GAP exit.
REQ-018 At sel=NUM_DIGITS-1, GAP exit SHALL wrap sel to 0 and pulse frame_done in the same cycle sel becomes 0.
REQ-019 First ACTIVE cycle (sel=0, dec_en=1) SHALL appear one clock after run is sampled high in IDLE.
REQ-020 run sampled low in any state SHALL force IDLE next cycle, with dec_en=0, sel=0, prescaler cleared, and no frame_done.
REQ-021 load=1 SHALL copy digits_in into the staging register next cycle and set the pending flag.
REQ-022 A later load before transfer SHALL overwrite staging; only the latest value is transferred.
REQ-023 Transfer staging to display register SHALL occur only at the frame wrap (REQ-018), or on the cycle after pending is set while in IDLE.
REQ-024 On transfer, pending SHALL clear and load_ack SHALL pulse for one cycle.
REQ-025 If load coincides with a transfer, the new value SHALL be staged and remain pending; it SHALL not be lost.
REQ-026 digit_out SHALL equal display register nibble[sel] in every cycle.
REQ-027 digit_out SHALL never change mid-frame, so no display tearing.

Reset
REQ-028 reset SHALL force IDLE.
REQ-029 reset SHALL clear to 0: sel, dec_en, digit_out, frame_done, load_ack, prescaler, staging, display register and pending.
REQ-030 reset SHALL take priority over run and load in the same cycle, including mid-frame.

Configuration
REQ-031 Macro DISPLAY_SCAN_BLANK_EN defined: leading-zero blanking is enabled.
- Blanked digits: every digit from NUM_DIGITS-1 downward whose display nibble is 0, up to the first nonzero digit.
- Blanked digits SHALL keep dec_en=0 during their ACTIVE slot.
- Slot timing and sel sequence SHALL be unchanged.
- Digit 0 SHALL never be blanked.
REQ-032 Macro undefined: every digit SHALL be lit during ACTIVE, and no blanking logic SHALL be present.

Structure
REQ-033 Shared package display_pkg SHALL hold:
- BCD width constant (4)
- max digit count (8)
- FSM state typedef/encoding
- digit-index width constant (3)
REQ-034 Sub-module scan_prescaler SHALL provide the slot counter. It takes clk, reset and clear, and outputs a terminal tick at count PRESCALE-1.

Verification
REQ-035 Check the following directed scenarios, all with PRESCALE=4 and NUM_DIGITS=8:
- Basic scan: reset, then run=1 -> sel steps 0..7, each slot is 3 cycles dec_en=1 plus 1 cycle dec_en=0, frame_done pulses every 32 cycles.
- Mid-frame load: load with digits_in=32'h1234_5678 mid-frame -> digit_out unchanged until wrap; load_ack and new digit_out (8 at sel=0) on the wrap cycle.
- Double load: load 32'h1111_1111 then 32'h2222_2222 within one frame -> single load_ack, display=32'h2222_2222.
- Run drop: run=0 at sel=5 -> next cycle IDLE, dec_en=0, sel=0, no frame_done; run=1 -> restarts at sel=0.
- Reset mid-frame: reset at sel=3 with pending load -> all outputs 0, pending lost, no load_ack.
- Blanking: DISPLAY_SCAN_BLANK_EN defined, display=32'h0000_0500 -> dec_en=0 in slots 7..3, lit in slots 2,1,0; display=0 -> only slot 0 lit.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants, FSM encoding and nibble helper for the display scan controller.
package display_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 8;
    localparam int SEL_W      = 3;
    localparam int DATA_W     = BCD_W * MAX_DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } scan_state_t;

    function automatic logic [BCD_W-1:0] nibble_at(
        input logic [DATA_W-1:0] d,
        input logic [SEL_W-1:0]  idx
    );
        return d[idx*BCD_W +: BCD_W];
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot counter: wraps modulo PRESCALE, tick marks the last count of a slot.
module scan_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed BCD display scanner with blanking gap and frame-synchronous reload.
// Optional leading-zero blanking: define DISPLAY_SCAN_BLANK_EN.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int PRESCALE   = 1000,
    parameter int NUM_DIGITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] digits_in,
    input  logic              load,
    output logic [SEL_W-1:0]  sel,
    output logic              dec_en,
    output logic [BCD_W-1:0]  digit_out,
    output logic              frame_done,
    output logic              load_ack
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

    scan_state_t       state_q, state_d;
    logic [SEL_W-1:0]  sel_d;
    logic              dec_en_d;
    logic              frame_done_d;
    logic              load_ack_d;
    logic [BCD_W-1:0]  digit_out_d;
    logic [DATA_W-1:0] staging_q, staging_d;
    logic [DATA_W-1:0] display_q, display_d;
    logic              pending_q, pending_d;
    logic              tick;
    logic              wrap;
    logic              xfer;
    logic              lit;

    // Counter runs 0 in GAP and 1..PRESCALE-1 across the lit part of a slot.
    scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (!run),
        .tick  (tick)
    );

    assign wrap = (state_q == ST_GAP) && run && (sel == LAST_SEL);
    assign xfer = pending_q && (wrap || (state_q == ST_IDLE));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!run)     state_d = ST_IDLE;
                else if (tick) state_d = ST_GAP;
            end
            ST_GAP: begin
                state_d = run ? ST_ACTIVE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        display_d = xfer ? staging_q : display_q;
        staging_d = load ? digits_in : staging_q;
        pending_d = load || (pending_q && !xfer);
        load_ack_d   = xfer;
        frame_done_d = wrap;
        sel_d = sel;
        if (state_d == ST_IDLE) begin
            sel_d = '0;
        end else if (state_q == ST_GAP) begin
            sel_d = wrap ? '0 : sel + 1'b1;
        end
    end

`ifdef DISPLAY_SCAN_BLANK_EN
    // Digit k is blank when it and every higher digit hold zero.
    logic [MAX_DIGITS-1:0] blank;

    always_comb begin
        logic lead;
        blank = '0;
        lead  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lead     = lead && (nibble_at(display_d, SEL_W'(k)) == '0);
            blank[k] = lead;
        end
    end

    assign lit = !blank[sel_d];
`else
    assign lit = 1'b1;
`endif

    assign dec_en_d    = (state_d == ST_ACTIVE) && lit;
    assign digit_out_d = nibble_at(display_d, sel_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel        <= '0;
            dec_en     <= 1'b0;
            digit_out  <= '0;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
            staging_q  <= '0;
            display_q  <= '0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel        <= sel_d;
            dec_en     <= dec_en_d;
            digit_out  <= digit_out_d;
            frame_done <= frame_done_d;
            load_ack   <= load_ack_d;
            staging_q  <= staging_d;
            display_q  <= display_d;
            pending_q  <= pending_d;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: time-based reference model feeds a
// per-cycle expectation queue drained by an independent monitor.
module tb_display_scan_ctrl;

    localparam int P     = 4;
    localparam int N     = 8;
    localparam int FRAME = P * N;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        load = 1'b0;
    logic [31:0] digits_in = '0;
    logic [2:0]  sel;
    logic        dec_en;
    logic [3:0]  digit_out;
    logic        frame_done;
    logic        load_ack;

    typedef struct packed {
        logic [2:0] sel;
        logic       dec_en;
        logic [3:0] digit;
        logic       fd;
        logic       ack;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Model state: m_t = cycles since scanning started, -1 when idle.
    int          m_t = -1;
    logic [31:0] m_disp = '0;
    logic [31:0] m_stage = '0;
    bit          m_pend = 1'b0;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .PRESCALE   (P),
        .NUM_DIGITS (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .digits_in  (digits_in),
        .load       (load),
        .sel        (sel),
        .dec_en     (dec_en),
        .digit_out  (digit_out),
        .frame_done (frame_done),
        .load_ack   (load_ack)
    );

    function automatic bit m_lit(input logic [31:0] d, input int s);
        if (s == 0) return 1'b1;
`ifdef DISPLAY_SCAN_BLANK_EN
        for (int k = s; k < N; k++)
            if (d[k*4 +: 4] != 4'd0) return 1'b1;
        return 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic step(input bit r, input bit rn, input bit ld,
                        input logic [31:0] din);
        exp_t e;
        int   s;
        bit   xf;
        @(negedge clk);
        reset     = r;
        run       = rn;
        load      = ld;
        digits_in = din;
        e = '0;
        if (r) begin
            m_t = -1;
            m_disp = '0;
            m_stage = '0;
            m_pend = 1'b0;
        end else begin
            xf = m_pend && (m_t < 0 || (rn && ((m_t + 1) % FRAME == 0)));
            if (xf) begin
                m_disp = m_stage;
                m_pend = 1'b0;
                e.ack  = 1'b1;
            end
            if (ld) begin
                m_stage = din;
                m_pend  = 1'b1;
            end
            if (!rn) m_t = -1;
            else     m_t = (m_t < 0) ? 0 : m_t + 1;
            s = 0;
            if (m_t >= 0) begin
                s        = (m_t / P) % N;
                e.sel    = 3'(s);
                e.dec_en = ((m_t % P) != P - 1) && m_lit(m_disp, s);
                e.fd     = (m_t > 0) && (m_t % FRAME == 0);
            end
            e.digit = m_disp[s*4 +: 4];
        end
        expq.push_back(e);
    endtask

    task automatic scan(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL cycle %0d %s: got %0h expected %0h", cyc, nm, got, want);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("sel", int'(sel), int'(e.sel));
                chk("dec_en", int'(dec_en), int'(e.dec_en));
                chk("digit_out", int'(digit_out), int'(e.digit));
                chk("frame_done", int'(frame_done), int'(e.fd));
                chk("load_ack", int'(load_ack), int'(e.ack));
            end
        end
    end

    initial begin
        bit          r;
        bit          ld;
        bit          rn;
        logic [31:0] d;

        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h9999_9999);
        scan(70);

        scan(5);
        step(1'b0, 1'b1, 1'b1, 32'h1234_5678);
        scan(40);

        step(1'b0, 1'b1, 1'b1, 32'h1111_1111);
        scan(6);
        step(1'b0, 1'b1, 1'b1, 32'h2222_2222);
        scan(40);

        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        scan(21);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        scan(36);

        step(1'b0, 1'b0, 1'b0, 32'h0);
        scan(13);
        step(1'b0, 1'b1, 1'b1, 32'h9876_5432);
        step(1'b1, 1'b1, 1'b1, 32'h4444_4444);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        scan(10);

        step(1'b0, 1'b0, 1'b1, 32'h0000_0500);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        scan(40);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0000);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        scan(40);

        rn = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(199) == 0);
            ld = ($urandom_range(19) == 0);
            if (rn) rn = ($urandom_range(99) != 0);
            else    rn = ($urandom_range(2) == 0);
            d = '0;
            for (int k = 0; k < 8; k++)
                if ($urandom_range(2) != 0) d[k*4 +: 4] = 4'($urandom_range(9));
            step(r, rn, ld, d);
        end

        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
